ps2_key_scanner: RTL and testbench

PS/2 keyboard front end that drives the key/ascii/count display top level. It synchronises the raw ps2_clk/ps2_data pins and deserialises 11-bit frames, then tracks make/break codes. It produces the level outputs key, is_press and count, and buffers decoded key events in a FIFO for a valid/ready consumer such as a text console.

---
 rtl/ps2_pkg.sv | 12 +
 rtl/ps2_key_scanner_if.sv | 9 +
 rtl/ps2_rx_frame.sv | 86 ++++++++
 rtl/ps2_key_scanner.sv | 118 +++++++++++
 tb/tb_ps2_key_scanner.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key scanner.
package ps2_pkg;
  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  typedef enum logic {IDLE, BREAK} dec_state_t;

  typedef struct packed {
    logic       is_break;
    logic [7:0] code;
  } ps2_ev_t;
endpackage

// File: rtl/ps2_key_scanner_if.sv
// Key-event stream: valid/ready handshake carrying {is_break, scan_code}.
interface ps2_key_scanner_if;
  logic       ev_valid;
  logic [8:0] ev_code;
  logic       ev_ready;

  modport master (output ev_valid, output ev_code, input ev_ready);
  modport slave  (input ev_valid, input ev_code, output ev_ready);
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 pin synchronisers and 11-bit frame receiver with frame check and
// stall timeout; emits accepted bytes as a one-cycle strobe.
module ps2_rx_frame #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_strobe,
  output logic       parity_err
);
  localparam int TW = $clog2(TIMEOUT_CYC);

  logic [2:0]    clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    byte_q, byte_d;
  logic          strobe_q, strobe_d, perr_q, perr_d;
  logic          fall, data_bit;

  assign fall     = clk_sync_q[2] & ~clk_sync_q[1];
  assign data_bit = data_sync_q[1];

  always_comb begin
    clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
    data_sync_d = {data_sync_q[1:0], ps2_data};
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tmo_d       = tmo_q;
    byte_d      = byte_q;
    strobe_d    = 1'b0;
    perr_d      = 1'b0;
    if (fall) begin
      tmo_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        // shift_q holds {parity, d7..d0, start}; the stop bit is live
        if (!shift_q[0] && data_bit && (^shift_q[9:1])) begin
          strobe_d = 1'b1;
          byte_d   = shift_q[8:1];
        end else begin
          perr_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        shift_d   = {data_bit, shift_q[9:1]};
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        bit_cnt_d = 4'd0;
        tmo_d     = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= 3'b111;
      data_sync_q <= 3'b111;
      bit_cnt_q   <= 4'd0;
      shift_q     <= '0;
      tmo_q       <= '0;
      byte_q      <= '0;
      strobe_q    <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tmo_q       <= tmo_d;
      byte_q      <= byte_d;
      strobe_q    <= strobe_d;
      perr_q      <= perr_d;
    end
  end

  assign rx_byte     = byte_q;
  assign byte_strobe = strobe_q;
  assign parity_err  = perr_q;
endmodule

// File: rtl/ps2_key_scanner.sv
// PS/2 keyboard front end: make/break decoder with key/is_press/count
// levels and a first-word fall-through event FIFO.
module ps2_key_scanner
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int COUNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  output logic [7:0]         key,
  output logic               is_press,
  output logic [COUNT_W-1:0] count,
  ps2_key_scanner_if.master  ev,
  output logic               parity_err,
  output logic               overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]         rx_byte;
  logic               byte_strobe;
  dec_state_t         state_q, state_d;
  logic [7:0]         key_q, key_d;
  logic               press_q, press_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               push, pop, full, empty, wr_en;
  ps2_ev_t            push_ev;
  logic [AW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic               overflow_q, overflow_d;
  logic [8:0]         mem_q [FIFO_DEPTH];

  ps2_rx_frame #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .byte_strobe(byte_strobe),
    .parity_err (parity_err)
  );

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    press_d = press_q;
    count_d = count_q;
    push    = 1'b0;
    push_ev = '{is_break: 1'b0, code: rx_byte};
    if (byte_strobe) begin
      unique case (state_q)
        IDLE: begin
          if (rx_byte == BREAK_CODE) begin
            state_d = BREAK;
          end else if (rx_byte != EXT_CODE) begin
            push = 1'b1;
            // a held key repeating is not a new press
            if (!(press_q && rx_byte == key_q)) begin
              key_d   = rx_byte;
              press_d = 1'b1;
              count_d = count_q + 1'b1;
            end
          end
        end
        BREAK: begin
          if (rx_byte != EXT_CODE) begin
            push             = 1'b1;
            push_ev.is_break = 1'b1;
            state_d          = IDLE;
            if (rx_byte == key_q) press_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
  assign pop        = !empty && ev.ev_ready;
  assign wr_en      = push && (!full || pop);
  assign wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
  assign overflow_d = overflow_q || (push && full && !pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_ev;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      key_q      <= 8'd0;
      press_q    <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      press_q    <= press_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  assign key         = key_q;
  assign is_press    = press_q;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign ev.ev_valid = !empty;
  assign ev.ev_code  = mem_q[rd_ptr_q[AW-1:0]];
endmodule

// File: tb/tb_ps2_key_scanner.sv
// Self-checking bench: frame table plus hand sequences, events checked
// against a scoreboard queue as the consumer pops them.
module tb_ps2_key_scanner;
  localparam int TMO = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key;
  logic       is_press;
  logic [7:0] count;
  logic       parity_err;
  logic       overflow;

  ps2_key_scanner_if ev_if ();

  ps2_key_scanner #(.FIFO_DEPTH(8), .TIMEOUT_CYC(TMO), .COUNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key       (key),
    .is_press  (is_press),
    .count     (count),
    .ev        (ev_if),
    .parity_err(parity_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int chk_cnt = 0, pass_cnt = 0, perr_seen = 0, pops = 0;
  logic [8:0] sb_q[$];

  task automatic check(string name, int act, int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (parity_err) perr_seen++;
      if (ev_if.ev_valid && ev_if.ev_ready) begin
        pops++;
        if (sb_q.size() == 0) check("ev_unexpected", int'(ev_if.ev_code), -1);
        else check("ev_code", int'(ev_if.ev_code), int'(sb_q.pop_front()));
      end
    end
  end

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    ps2_clk  = 1'b1;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] c, input bit bad);
    logic [10:0] f;
    f = {1'b1, (~^c) ^ bad, c, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_key", int'(key), 0);
    check("rst_press", int'(is_press), 0);
    check("rst_count", int'(count), 0);
    check("rst_valid", int'(ev_if.ev_valid), 0);
    check("rst_perr", int'(parity_err), 0);
    check("rst_ovf", int'(overflow), 0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] code;
    bit         bad;
    logic [7:0] e_key;
    bit         e_press;
    int         e_count;
    int         e_perr;
    bit         push;
    logic [8:0] ev;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int p0;
    logic [7:0] c;
    tbl[0]  = '{8'h1C, 0, 8'h1C, 1, 1, 0, 1, 9'h01C};
    tbl[1]  = '{8'h1C, 0, 8'h1C, 1, 1, 0, 1, 9'h01C};
    tbl[2]  = '{8'hF0, 0, 8'h1C, 1, 1, 0, 0, 9'h000};
    tbl[3]  = '{8'h1C, 0, 8'h1C, 0, 1, 0, 1, 9'h11C};
    tbl[4]  = '{8'h32, 1, 8'h1C, 0, 1, 1, 0, 9'h000};
    tbl[5]  = '{8'hE0, 0, 8'h1C, 0, 1, 0, 0, 9'h000};
    tbl[6]  = '{8'h5A, 0, 8'h5A, 1, 2, 0, 1, 9'h05A};
    tbl[7]  = '{8'hF0, 0, 8'h5A, 1, 2, 0, 0, 9'h000};
    tbl[8]  = '{8'hE0, 0, 8'h5A, 1, 2, 0, 0, 9'h000};
    tbl[9]  = '{8'h33, 0, 8'h5A, 1, 2, 0, 1, 9'h133};
    tbl[10] = '{8'h5A, 0, 8'h5A, 1, 2, 0, 1, 9'h05A};

    ev_if.ev_ready = 1'b1;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 11; i++) begin
      p0 = perr_seen;
      if (tbl[i].push) sb_q.push_back(tbl[i].ev);
      send_frame(tbl[i].code, tbl[i].bad);
      check($sformatf("tbl%0d_key", i), int'(key), int'(tbl[i].e_key));
      check($sformatf("tbl%0d_press", i), int'(is_press), int'(tbl[i].e_press));
      check($sformatf("tbl%0d_count", i), int'(count), tbl[i].e_count);
      check($sformatf("tbl%0d_perr", i), perr_seen - p0, tbl[i].e_perr);
    end
    check("tbl_sb_empty", sb_q.size(), 0);
    check("tbl_valid", int'(ev_if.ev_valid), 0);

    // partial frame abandoned by the timeout, then a clean frame
    p0 = perr_seen;
    for (int i = 0; i < 5; i++) ps2_bit(1'b0);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (TMO + 10) @(negedge clk);
    sb_q.push_back(9'h024);
    send_frame(8'h24, 0);
    check("tmo_key", int'(key), 8'h24);
    check("tmo_press", int'(is_press), 1);
    check("tmo_count", int'(count), 3);
    check("tmo_perr", perr_seen - p0, 0);
    check("tmo_sb_empty", sb_q.size(), 0);

    do_reset();
    for (int i = 0; i < 256; i++) begin
      c = (i % 2 == 1) ? 8'h1D : 8'h15;
      sb_q.push_back({1'b0, c});
      send_frame(c, 0);
      send_frame(8'hF0, 0);
      sb_q.push_back({1'b1, c});
      send_frame(c, 0);
    end
    check("wrap_count", int'(count), 0);
    check("wrap_press", int'(is_press), 0);
    check("wrap_key", int'(key), 8'h1D);
    check("wrap_sb_empty", sb_q.size(), 0);

    // nine makes into an eight-deep FIFO with the consumer stalled
    ev_if.ev_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      c = 8'h16 + 8'(i);
      if (i < 8) sb_q.push_back({1'b0, c});
      send_frame(c, 0);
    end
    check("ovf_flag", int'(overflow), 1);
    check("ovf_valid", int'(ev_if.ev_valid), 1);
    check("ovf_count", int'(count), 9);
    check("ovf_key", int'(key), 8'h1E);
    p0 = pops;
    ev_if.ev_ready = 1'b1;
    for (int k = 0; k < 100 && ev_if.ev_valid; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("drain_pops", pops - p0, 8);
    check("drain_valid", int'(ev_if.ev_valid), 0);
    check("drain_sb_empty", sb_q.size(), 0);
    check("ovf_sticky", int'(overflow), 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
